sd_drive_arbiter: RTL
=====================

// Module: sd_drive_arbiter
// PURPOSE
//  Connects NUM_DRIVES virtual drives (floppies, SCSI) to the single sd_rw
//  sector engine. Each drive gets its own LBA region on the card, and requests
//  are granted round-robin, one at a time. It sits between the macplus sdc_*
//  bus and sd_rw, replacing the ad-hoc OR of rd|wr into sector[31:24].
// PARAMETERS
//  NUM_DRIVES    4   number of drive request channels (1..8)
//  DRV_LBA_W     24  width of per-drive LBA from the core
//  REGION_SHIFT  21  log2 sectors per drive region (2^21 = 1 GiB)
//  BASE_LBA      0   card LBA of drive 0 region
//  TIMEOUT_CYC   2^20  watchdog limit in clk cycles (SD_TIMEOUT_EN only)
// PORTS
//  clk           in   1            system clock (16/32 MHz)
//  rstn          in   1            synchronous reset, active-low
//  drv_rd        in   NUM_DRIVES   read request, one bit per drive (level)
//  drv_wr        in   NUM_DRIVES   write request, one bit per drive (level)
//  drv_lba       in   NUM_DRIVES*DRV_LBA_W  packed per-drive sector number
//  drv_dout      in   NUM_DRIVES*8 packed per-drive write byte
//  drv_busy      out  1            arbiter owns the card (any drive active)
//  drv_done      out  NUM_DRIVES   1-cycle completion pulse to granted drive
//  drv_err       out  NUM_DRIVES   1-cycle error pulse, coincident with done
//  drv_data_en   out  NUM_DRIVES   byte strobe, gated to granted drive only
//  drv_addr      out  9            byte index in sector (0..511)
//  drv_din       out  8            read byte, broadcast
//  sd_rstart     out  1            read start to sd_rw
//  sd_wstart     out  1            write start to sd_rw
//  sd_sector     out  32           physical card LBA
//  sd_busy       in   1            sd_rw busy
//  sd_done       in   1            sd_rw done pulse
//  sd_outen      in   1            sd_rw byte strobe
//  sd_outaddr    in   9            sd_rw byte index
//  sd_outbyte    in   8            sd_rw read byte
//  sd_inbyte     out  8            write byte muxed from granted drive
// BEHAVIOUR
//  - Reset (rstn=0 at clk edge): every output is 0, FSM goes to IDLE, grant
//    and round-robin pointer go to 0. A reset in mid-transfer drops the
//    transfer, and no done pulse is issued.
//  - Request = drv_rd[i]|drv_wr[i] while in IDLE. When both are set, rd wins.
//    A drive must hold its request until its done pulse.
//  - Arbitration: round-robin, searching from ptr+1 (mod NUM_DRIVES). On grant,
//    ptr<=g. With only one requester, it is granted every time.
//  - Mapping: sd_sector = BASE_LBA + (g<<REGION_SHIFT) + drv_lba[g], 32-bit
//    wrap. If drv_lba[g] >= 2^REGION_SHIFT, the request goes to DONE with
//    err=1, and no card access is made.
//  - FSM states and transitions:
//    - IDLE  -> ISSUE on any request. The cycle of the request is the grant
//      cycle.
//    - ISSUE: drive sd_rstart or sd_wstart = 1 for exactly one cycle with
//      sd_sector stable, then WAIT.
//    - WAIT: stay until sd_busy=1, then XFER.
//    - XFER: stay until sd_done=1, then DONE.
//    - DONE: drv_done[g]=1 for one cycle, then IDLE. Request bits are ignored
//      in DONE, which avoids re-granting a request still held from before.
//  - Timing: drv_done fires 1 cycle after sd_done. sd_start fires 2 cycles
//    after the request is seen in IDLE.
//  - sd_sector and the granted index are registered at grant and held until
//    IDLE. drv_busy=1 in every state except IDLE.
//  - Byte path:
//    - drv_data_en[g] = sd_outen while in XFER; other drives see 0.
//    - drv_addr = sd_outaddr; drv_din = sd_outbyte (combinational).
//    - sd_inbyte = drv_dout[g] (combinational).
// CONFIGURATION
//  SD_TIMEOUT_EN defined:
//   - A 32-bit counter clears on entry to WAIT and counts in WAIT and XFER.
//   - Reaching TIMEOUT_CYC -> DONE with drv_err[g]=1.
//   - Meant for an absent or hung card.
//  SD_TIMEOUT_EN undefined:
//   - No counter; WAIT and XFER wait indefinitely.
//   - drv_err fires only on a region overflow.
// TESTING
//  1 drv_rd=4'b0001, lba0=5, BASE_LBA=0 -> sd_rstart 1-cycle pulse,
//    sd_sector=5; sd_done -> drv_done=0001 one cycle later, drv_err=0.
//  2 drv_wr[2]=1, lba2=0x10 -> sd_wstart, sd_sector=0x00400010;
//    sd_inbyte follows drv_dout[23:16].
//  3 all 4 drives request together from reset -> grants 1,2,3,0 in order,
//    one transfer at a time; drv_data_en only on the granted bit.
//  4 lba1=0x200000 (REGION_SHIFT=21) -> no sd_*start; drv_done[1]=drv_err[1]=1.
//  5 rstn=0 during XFER -> next cycle all outputs 0 and IDLE; no drv_done;
//    a held request is re-granted after release.
//  6 SD_TIMEOUT_EN, TIMEOUT_CYC=100, sd_busy stuck 0 -> drv_done and drv_err
//    pulse 100 cycles after WAIT entry.

Source files
------------

// File: rtl/sd_drive_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter_if
// Purpose  : Drive-side request bus plus sd_rw engine bus seen by the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface sd_drive_arbiter_if #(
    parameter int NUM_DRIVES = 4,
    parameter int DRV_LBA_W  = 24
);
    logic [NUM_DRIVES-1:0]           drv_rd;
    logic [NUM_DRIVES-1:0]           drv_wr;
    logic [NUM_DRIVES*DRV_LBA_W-1:0] drv_lba;
    logic [NUM_DRIVES*8-1:0]         drv_dout;
    logic                            drv_busy;
    logic [NUM_DRIVES-1:0]           drv_done;
    logic [NUM_DRIVES-1:0]           drv_err;
    logic [NUM_DRIVES-1:0]           drv_data_en;
    logic [8:0]                      drv_addr;
    logic [7:0]                      drv_din;

    logic                            sd_rstart;
    logic                            sd_wstart;
    logic [31:0]                     sd_sector;
    logic                            sd_busy;
    logic                            sd_done;
    logic                            sd_outen;
    logic [8:0]                      sd_outaddr;
    logic [7:0]                      sd_outbyte;
    logic [7:0]                      sd_inbyte;

    // Arbiter view
    modport slave (
        input  drv_rd, drv_wr, drv_lba, drv_dout,
        input  sd_busy, sd_done, sd_outen, sd_outaddr, sd_outbyte,
        output drv_busy, drv_done, drv_err, drv_data_en, drv_addr, drv_din,
        output sd_rstart, sd_wstart, sd_sector, sd_inbyte
    );

    // Surrounding core / sd_rw view
    modport master (
        output drv_rd, drv_wr, drv_lba, drv_dout,
        output sd_busy, sd_done, sd_outen, sd_outaddr, sd_outbyte,
        input  drv_busy, drv_done, drv_err, drv_data_en, drv_addr, drv_din,
        input  sd_rstart, sd_wstart, sd_sector, sd_inbyte
    );
endinterface
`default_nettype wire

// File: rtl/sd_drive_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_drive_arbiter
// Purpose  : Round-robin sharing of one sd_rw sector engine among NUM_DRIVES
//            virtual drives, each mapped to its own LBA region on the card.
//            Optional watchdog enabled by defining SD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sd_drive_arbiter #(
    parameter int          NUM_DRIVES   = 4,
    parameter int          DRV_LBA_W    = 24,
    parameter int          REGION_SHIFT = 21,
    parameter logic [31:0] BASE_LBA     = 32'd0,
    parameter logic [31:0] TIMEOUT_CYC  = 32'd1048576
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    sd_drive_arbiter_if.slave bus
);

    localparam int c_IDX_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_XFER  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_grant;
    logic [c_IDX_W-1:0]   r_ptr;
    logic [c_IDX_W-1:0]   w_pick;
    int                   w_best;
    logic                 r_is_rd;
    logic                 r_err;
    logic [31:0]          r_sector;
    logic                 r_sd_rstart;
    logic                 r_sd_wstart;

    logic [NUM_DRIVES-1:0] w_req;
    logic                  w_any_req;
    logic [DRV_LBA_W-1:0]  w_lba  [NUM_DRIVES];
    logic [7:0]            w_dout [NUM_DRIVES];
    logic [31:0]           w_lba_ext;
    logic [31:0]           w_sector;
    logic                  w_ovf;
    logic                  w_pick_rd;
    logic                  w_timeout_err;
    logic [NUM_DRIVES-1:0] w_grant_oh;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DRIVES; gi++) begin : g_unpack
            assign w_lba[gi]  = bus.drv_lba[gi*DRV_LBA_W +: DRV_LBA_W];
            assign w_dout[gi] = bus.drv_dout[gi*8 +: 8];
        end
    endgenerate

    assign w_req     = bus.drv_rd | bus.drv_wr;
    assign w_any_req = |w_req;

    // Round-robin: the requester closest after r_ptr (cyclically) wins.
    always_comb begin
        w_pick = '0;
        w_best = NUM_DRIVES;
        for (int j = 0; j < NUM_DRIVES; j++) begin
            if (w_req[j] &&
                (((j - int'(r_ptr) - 1 + 2*NUM_DRIVES) % NUM_DRIVES) < w_best)) begin
                w_best = (j - int'(r_ptr) - 1 + 2*NUM_DRIVES) % NUM_DRIVES;
                w_pick = c_IDX_W'(j);
            end
        end
    end

    assign w_pick_rd = bus.drv_rd[w_pick];
    assign w_lba_ext = 32'(w_lba[w_pick]);
    assign w_ovf     = (w_lba_ext >> REGION_SHIFT) != 32'd0;
    assign w_sector  = BASE_LBA + (32'(w_pick) << REGION_SHIFT) + w_lba_ext;

`ifdef SD_TIMEOUT_EN
    logic [31:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= 32'd0;
        end else if (r_state == S_ISSUE) begin
            r_cnt <= 32'd0;
        end else if (r_state == S_WAIT || r_state == S_XFER) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    // A completion arriving on the very last cycle still counts as success.
    assign w_timeout_err = ((r_state == S_WAIT) ||
                            (r_state == S_XFER && !bus.sd_done)) &&
                           (r_cnt == TIMEOUT_CYC - 32'd1);
`else
    assign w_timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_ptr       <= '0;
            r_is_rd     <= 1'b0;
            r_err       <= 1'b0;
            r_sector    <= 32'd0;
            r_sd_rstart <= 1'b0;
            r_sd_wstart <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sd_rstart <= (r_state == S_ISSUE) &&  r_is_rd;
            r_sd_wstart <= (r_state == S_ISSUE) && !r_is_rd;
            if (r_state == S_IDLE && w_any_req) begin
                r_grant  <= w_pick;
                r_ptr    <= w_pick;
                r_is_rd  <= w_pick_rd;
                r_err    <= w_ovf;
                r_sector <= w_sector;
            end else if (w_timeout_err) begin
                r_err    <= 1'b1;
            end
        end
    end

    assign w_grant_oh = NUM_DRIVES'(1) << r_grant;

    always_comb begin
        w_state_nxt     = r_state;
        bus.drv_busy    = (r_state != S_IDLE);
        bus.drv_done    = '0;
        bus.drv_err     = '0;
        bus.drv_data_en = '0;
        bus.drv_addr    = bus.sd_outaddr;
        bus.drv_din     = bus.sd_outbyte;
        bus.sd_rstart   = r_sd_rstart;
        bus.sd_wstart   = r_sd_wstart;
        bus.sd_sector   = r_sector;
        bus.sd_inbyte   = w_dout[r_grant];

        unique case (r_state)
            S_IDLE: begin
                // Out-of-region requests complete with an error, no card access.
                if (w_any_req) begin
                    w_state_nxt = w_ovf ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_timeout_err) begin
                    w_state_nxt = S_DONE;
                end else if (bus.sd_busy) begin
                    w_state_nxt = S_XFER;
                end
            end
            S_XFER: begin
                if (bus.sd_outen) begin
                    bus.drv_data_en = w_grant_oh;
                end
                if (bus.sd_done || w_timeout_err) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.drv_done = w_grant_oh;
                bus.drv_err  = r_err ? w_grant_oh : '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
